testeio_leds_pio: RTL and testbench
===================================

TESTEIO_LEDS_PIO -- requirements
Module: testeio_leds_pio

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the output port width (1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the DATA register value after reset.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1, is the asynchronous active-low reset.
REQ-006 Port address, input, 3, is the Avalon-MM word address.
REQ-007 Port chipselect, input, 1, is the slave select and qualifies writes.
REQ-008 Port write_n, input, 1, is the active-low write strobe.
REQ-009 Port writedata, input, 32, is the write data.
REQ-010 Port readdata, output, 32, is the registered read data.
REQ-011 Port out_port, output, DATA_WIDTH, is driven directly from the DATA register.

Function
REQ-012 A write SHALL occur in a cycle where chipselect=1 and write_n=0.
REQ-013 The register map SHALL be: 0 DATA (R/W); 1 PULSE_LEN (R/W, 16 bits); 2 PULSE_MASK (R/W, DATA_WIDTH bits); 3 COUNT (RO); 4 OUTSET (WO); 5 OUTCLEAR (WO); 6-7 reserved.
REQ-014 A DATA write SHALL load writedata[DATA_WIDTH-1:0], and out_port SHALL show it on the next cycle.
REQ-015 An OUTSET write SHALL perform DATA |= writedata, and an OUTCLEAR write SHALL perform DATA &= ~writedata.
REQ-016 readdata SHALL update every cycle, independent of chipselect, to the zero-extended mux of address, with one-cycle latency.
REQ-017 Reads of OUTSET, OUTCLEAR and reserved addresses SHALL return 0, and writes to reserved addresses SHALL be ignored.
REQ-018 A pulse trigger SHALL be any write to DATA or OUTSET that produces a 0->1 transition on a DATA bit whose PULSE_MASK bit is 1.
REQ-019 On a trigger with PULSE_LEN!=0, COUNT SHALL load PULSE_LEN on the next edge; a retrigger while COUNT!=0 SHALL reload it.
REQ-020 While COUNT>1 and no trigger occurs, COUNT SHALL decrement by 1 per cycle.
REQ-021 When COUNT==1 and no trigger occurs, on the next edge DATA SHALL become DATA & ~PULSE_MASK and COUNT SHALL become 0, so masked bits stay high for exactly PULSE_LEN cycles after the write edge.
REQ-022 A trigger in the expiry cycle SHALL win: the write SHALL be applied, COUNT SHALL reload, and no auto-clear SHALL occur.
REQ-023 A non-trigger DATA/OUTCLEAR write in the expiry cycle SHALL be applied first, and the auto-clear SHALL then apply to the result.
REQ-024 With PULSE_LEN==0, triggers SHALL be ignored and COUNT SHALL stay 0.
REQ-025 Writing PULSE_LEN or PULSE_MASK SHALL NOT alter a running COUNT; the new mask SHALL apply at expiry.
REQ-026 COUNT SHALL be 16 bits and SHALL never wrap below 0.

Reset
REQ-027 While reset_n=0, DATA SHALL be RESET_VALUE, PULSE_LEN=0, PULSE_MASK=0, COUNT=0 and readdata=0, asynchronously.
REQ-028 Deassertion of reset in the middle of a pulse SHALL leave no pending auto-clear.

Configuration
REQ-029 With macro TESTEIO_PIO_PULSE_EN defined, REQ-018..026 SHALL be implemented.
REQ-030 Without TESTEIO_PIO_PULSE_EN, the PULSE_LEN, PULSE_MASK and COUNT logic SHALL be absent, addresses 1-3 SHALL read 0, and writes to them SHALL be ignored; DATA, OUTSET and OUTCLEAR behaviour SHALL be unchanged.

Structure
REQ-031 Shared package testeio_pio_pkg SHALL hold the address constants (ADDR_DATA..ADDR_OUTCLEAR) and PULSE_LEN_W=16.
REQ-032 The counter SHALL be a sub-module testeio_pio_pulse_timer (inputs trigger and len; outputs count and expire), instantiated only under TESTEIO_PIO_PULSE_EN.

Verification
REQ-033 Reset, then write DATA=0xA5 -> out_port=0xA5 one cycle later; a read of address 0 returns 0x000000A5 one cycle after address is presented.
REQ-034 DATA=0x0F, OUTSET 0xF0, OUTCLEAR 0x03 -> out_port=0xFF, then 0xFC.
REQ-035 PULSE_LEN=3, PULSE_MASK=0x1, OUTSET 0x1 -> bit0 high for exactly 3 cycles, and COUNT reads 3,2,1,0.
REQ-036 PULSE_LEN=4: OUTSET 0x1, clear bit0 via OUTCLEAR after 2 cycles, OUTSET 0x1 again in the expiry cycle -> bit0 high and COUNT=4, with no clear that cycle.
REQ-037 Assert reset_n=0 with COUNT=5 -> out_port=RESET_VALUE and COUNT=0 immediately, and no auto-clear occurs after release.
REQ-038 Build without TESTEIO_PIO_PULSE_EN, write 0x7 to address 1 -> a read of address 1 returns 0, and DATA is unchanged.

Source files
------------

// File: rtl/testeio_pio_pkg.sv
// testeio_pio_pkg: register map, bus width and pulse-timer width shared by
// the LED PIO top level, its pulse timer and anything that talks to them.
package testeio_pio_pkg;

  localparam int BUS_W       = 32;
  localparam int PULSE_LEN_W = 16;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd1;
  localparam logic [2:0] ADDR_PULSE_MASK = 3'd2;
  localparam logic [2:0] ADDR_COUNT      = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

  // Only writes that can raise DATA bits (a plain load or a set) may start a pulse.
  function automatic logic is_pulse_source(input logic [2:0] addr);
    return (addr == ADDR_DATA) || (addr == ADDR_OUTSET);
  endfunction

endpackage

// File: rtl/testeio_pio_pulse_timer.sv
// testeio_pio_pulse_timer: down-counter that times how long pulse-masked
// DATA bits stay high. A trigger with a non-zero length (re)loads the count;
// expire is raised in the cycle the count sits at 1 and is not being reloaded,
// which is the cycle whose closing edge must clear the masked bits.
module testeio_pio_pulse_timer
  import testeio_pio_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trigger,
  input  logic [PULSE_LEN_W-1:0] len,
  output logic [PULSE_LEN_W-1:0] count,
  output logic                   expire
);

  logic load;

  // A zero length disables pulsing, so such a trigger neither loads nor blocks expiry.
  assign load   = trigger && (len != '0);
  assign expire = (count == PULSE_LEN_W'(1)) && !load;

  // Reload on trigger, otherwise count down and stop at zero without wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= len;
    end else if (count != '0) begin
      count <= count - PULSE_LEN_W'(1);
    end
  end

endmodule

// File: rtl/testeio_leds_pio.sv
// testeio_leds_pio: Avalon-MM LED output port with DATA, set (OUTSET) and
// clear (OUTCLEAR) access and a registered read path. Defining the macro
// TESTEIO_PIO_PULSE_EN adds PULSE_LEN, PULSE_MASK and COUNT: a write that
// raises a masked DATA bit keeps the masked bits high for PULSE_LEN cycles,
// after which they are cleared automatically. Without the macro those
// registers read as zero and writes to them are dropped.
module testeio_leds_pio
  import testeio_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_wr;
  logic [DATA_WIDTH-1:0] data_next;
  logic [BUS_W-1:0]      read_mux;

  assign wr_en   = chipselect && !write_n;
  assign wr_data = writedata[DATA_WIDTH-1:0];

  // DATA after this cycle's bus write alone, before any pulse expiry is applied.
  always_comb begin
    data_wr = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_wr = wr_data;
        ADDR_OUTSET:   data_wr = data_q | wr_data;
        ADDR_OUTCLEAR: data_wr = data_q & ~wr_data;
        default:       data_wr = data_q;
      endcase
    end
  end

`ifdef TESTEIO_PIO_PULSE_EN
  logic [PULSE_LEN_W-1:0] pulse_len_q;
  logic [DATA_WIDTH-1:0]  pulse_mask_q;
  logic [PULSE_LEN_W-1:0] count;
  logic                   expire;
  logic                   trigger;
  logic [DATA_WIDTH-1:0]  rising;

  // Masked bits that this write takes from 0 to 1; any such bit starts a pulse.
  assign rising  = ~data_q & data_wr & pulse_mask_q;
  assign trigger = wr_en && is_pulse_source(address) && (rising != '0);

  testeio_pio_pulse_timer u_pulse_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (trigger),
    .len     (pulse_len_q),
    .count   (count),
    .expire  (expire)
  );

  // On expiry the clear lands on top of whatever the bus wrote this cycle.
  assign data_next = expire ? (data_wr & ~pulse_mask_q) : data_wr;

  // Pulse configuration; changing it never disturbs a count already running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len_q  <= '0;
      pulse_mask_q <= '0;
    end else if (wr_en) begin
      if (address == ADDR_PULSE_LEN) begin
        pulse_len_q <= writedata[PULSE_LEN_W-1:0];
      end
      if (address == ADDR_PULSE_MASK) begin
        pulse_mask_q <= wr_data;
      end
    end
  end
`else
  assign data_next = data_wr;
`endif

  // DATA register, which also drives the LED pins directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE[DATA_WIDTH-1:0];
    end else begin
      data_q <= data_next;
    end
  end

  assign out_port = data_q;

  // Zero-extended register select; write-only and reserved addresses read as zero.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:       read_mux[DATA_WIDTH-1:0]  = data_q;
`ifdef TESTEIO_PIO_PULSE_EN
      ADDR_PULSE_LEN:  read_mux[PULSE_LEN_W-1:0] = pulse_len_q;
      ADDR_PULSE_MASK: read_mux[DATA_WIDTH-1:0]  = pulse_mask_q;
      ADDR_COUNT:      read_mux[PULSE_LEN_W-1:0] = count;
`endif
      default:         read_mux = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_testeio_leds_pio.sv
// tb_testeio_leds_pio: directed bench for testeio_leds_pio. A cycle-indexed
// model tracks DATA and, when TESTEIO_PIO_PULSE_EN is defined, the pulse as an
// absolute deadline cycle; a negedge process compares the DUT with it every
// cycle, and literal checks pin the model at the interesting points.
module tb_testeio_leds_pio;
  import testeio_pio_pkg::*;

  localparam int          DW = 32;
  localparam logic [31:0] RV = 32'h0000_0081;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  int n_vectors     = 0;
  int n_miscompares = 0;
  bit checking      = 1'b0;

  logic [31:0] m_data;
  logic [31:0] m_len;
  logic [31:0] m_mask;
  logic [31:0] m_rd;
  longint      cyc;
  longint      deadline;
  bit          active;

  testeio_leds_pio #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Cycles left before the masked bits drop, as COUNT should show it.
  function automatic logic [31:0] modelCount();
    return active ? 32'(deadline - cyc) : 32'd0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 3'd0) v = m_data;
`ifdef TESTEIO_PIO_PULSE_EN
    if (a == 3'd1) v = m_len;
    if (a == 3'd2) v = m_mask;
    if (a == 3'd3) v = modelCount();
`endif
    return v;
  endfunction

  task automatic modelReset();
    m_data   = RV;
    m_len    = 32'd0;
    m_mask   = 32'd0;
    m_rd     = 32'd0;
    cyc      = 0;
    deadline = 0;
    active   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs the DUT sampled.
  task automatic modelStep();
    logic [31:0] old_d;
    logic [31:0] nd;
    bit          wr;
    bit          trig;
    wr    = chipselect && !write_n;
    old_d = m_data;
    nd    = m_data;
    m_rd  = modelRead(address);
    cyc++;
    if (wr && address == 3'd0) nd = writedata;
    if (wr && address == 3'd4) nd = old_d | writedata;
    if (wr && address == 3'd5) nd = old_d & ~writedata;
    trig = 1'b0;
`ifdef TESTEIO_PIO_PULSE_EN
    trig = wr && (address == 3'd0 || address == 3'd4) &&
           ((~old_d & nd & m_mask) != 32'd0) && (m_len != 32'd0);
    if (trig) begin
      deadline = cyc + longint'(m_len);
      active   = 1'b1;
    end else if (active && deadline == cyc) begin
      nd     = nd & ~m_mask;
      active = 1'b0;
    end
    if (wr && address == 3'd1) m_len  = writedata & 32'h0000_FFFF;
    if (wr && address == 3'd2) m_mask = writedata;
`endif
    m_data = nd;
  endtask

  // Drive one bus cycle, let it be clocked in, and move the model with it.
  task automatic applyStimulus(input logic [2:0] a, input logic cs, input logic wn,
                               input logic [31:0] wd);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] wd);
    applyStimulus(a, 1'b1, 1'b0, wd);
  endtask

  task automatic readReg(input logic [2:0] a);
    applyStimulus(a, 1'b0, 1'b1, 32'hDEAD_BEEF);
  endtask

  task automatic checkLiteral(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    n_vectors++;
    if (out_port !== m_data[DW-1:0]) begin
      n_miscompares++;
      $display("[TB] FAIL out_port cycle %0d: got %h, expected %h", cyc, out_port, m_data[DW-1:0]);
    end
    n_vectors++;
    if (readdata !== m_rd) begin
      n_miscompares++;
      $display("[TB] FAIL readdata cycle %0d: got %h, expected %h", cyc, readdata, m_rd);
    end
  endtask

  // Every cycle out of reset, the DUT must agree with the model.
  always @(negedge clk) begin
    if (checking && reset_n === 1'b1) checkOutput();
  end

  // Called just after a rising edge: assert reset mid-cycle, check it acts at once, release.
  task automatic applyReset();
    reset_n = 1'b0;
    #2;
    checkLiteral("reset out_port", out_port, RV);
    checkLiteral("reset readdata", readdata, 32'd0);
    modelReset();
    #4;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    #1;
    applyReset();
    checking = 1'b1;

    readReg(3'd0);
    checkLiteral("read DATA after reset", readdata, RV);

    writeReg(ADDR_DATA, 32'h0000_00A5);
    checkLiteral("DATA write to out_port", out_port, 32'h0000_00A5);
    readReg(3'd0);
    checkLiteral("DATA readback", readdata, 32'h0000_00A5);

    writeReg(ADDR_DATA, 32'h0000_000F);
    writeReg(ADDR_OUTSET, 32'h0000_00F0);
    checkLiteral("OUTSET result", out_port, 32'h0000_00FF);
    writeReg(ADDR_OUTCLEAR, 32'h0000_0003);
    checkLiteral("OUTCLEAR result", out_port, 32'h0000_00FC);

    for (int a = 4; a < 8; a++) begin
      readReg(3'(a));
      checkLiteral("WO/reserved read", readdata, 32'd0);
    end
    writeReg(3'd6, 32'hFFFF_FFFF);
    writeReg(3'd7, 32'h0000_0000);
    checkLiteral("reserved write ignored", out_port, 32'h0000_00FC);
    applyStimulus(ADDR_DATA, 1'b0, 1'b0, 32'h1234_5678);
    checkLiteral("write without chipselect", out_port, 32'h0000_00FC);
    applyStimulus(ADDR_OUTSET, 1'b1, 1'b1, 32'hFFFF_FFFF);
    checkLiteral("chipselect without write_n", out_port, 32'h0000_00FC);
    writeReg(ADDR_DATA, 32'h8000_0001);
    readReg(3'd0);
    checkLiteral("full width readback", readdata, 32'h8000_0001);
    writeReg(ADDR_OUTCLEAR, 32'h8000_0001);
    writeReg(ADDR_OUTSET, 32'h0000_00FC);

`ifdef TESTEIO_PIO_PULSE_EN
    writeReg(ADDR_PULSE_LEN, 32'hABCD_0003);
    writeReg(ADDR_PULSE_MASK, 32'h0000_0001);
    readReg(ADDR_PULSE_LEN);
    checkLiteral("PULSE_LEN readback", readdata, 32'h0000_0003);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    checkLiteral("pulse start", out_port, 32'h0000_00FD);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT 3", readdata, 32'd3);
    checkLiteral("pulse high 2", out_port, 32'h0000_00FD);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT 2", readdata, 32'd2);
    checkLiteral("pulse high 3", out_port, 32'h0000_00FD);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT 1", readdata, 32'd1);
    checkLiteral("pulse cleared", out_port, 32'h0000_00FC);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT 0", readdata, 32'd0);

    writeReg(ADDR_PULSE_LEN, 32'd4);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    readReg(ADDR_COUNT);
    writeReg(ADDR_OUTCLEAR, 32'h0000_0001);
    readReg(ADDR_COUNT);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    checkLiteral("retrigger at expiry wins", out_port, 32'h0000_00FD);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT reloaded", readdata, 32'd4);
    readReg(ADDR_COUNT);
    readReg(ADDR_COUNT);
    writeReg(ADDR_DATA, 32'h0000_F0F1);
    checkLiteral("write then clear at expiry", out_port, 32'h0000_F0F0);

    writeReg(ADDR_PULSE_LEN, 32'd0);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    for (int i = 0; i < 4; i++) readReg(ADDR_COUNT);
    checkLiteral("len 0 no pulse", out_port, 32'h0000_F0F1);
    checkLiteral("len 0 COUNT", readdata, 32'd0);

    writeReg(ADDR_PULSE_LEN, 32'd5);
    writeReg(ADDR_OUTCLEAR, 32'h0000_00FF);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    writeReg(ADDR_PULSE_MASK, 32'h0000_1000);
    writeReg(ADDR_PULSE_LEN, 32'd9);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT unaffected by config", readdata, 32'd3);
    readReg(ADDR_PULSE_MASK);
    readReg(ADDR_COUNT);
    checkLiteral("new mask at expiry", out_port, 32'h0000_E001);

    writeReg(ADDR_PULSE_MASK, 32'h0000_0001);
    writeReg(ADDR_PULSE_LEN, 32'd8);
    writeReg(ADDR_OUTCLEAR, 32'h0000_0001);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    readReg(ADDR_COUNT);
    readReg(ADDR_COUNT);
    readReg(ADDR_COUNT);
    checkLiteral("COUNT before reset", readdata, 32'd6);
    applyReset();
    writeReg(ADDR_PULSE_MASK, 32'h0000_0001);
    for (int i = 0; i < 8; i++) readReg(ADDR_COUNT);
    checkLiteral("no clear after reset", out_port, RV);
    checkLiteral("COUNT after reset", readdata, 32'd0);
`else
    writeReg(ADDR_DATA, 32'h0000_003C);
    writeReg(ADDR_PULSE_LEN, 32'h0000_0007);
    readReg(ADDR_PULSE_LEN);
    checkLiteral("addr 1 reads 0", readdata, 32'd0);
    checkLiteral("addr 1 write ignored", out_port, 32'h0000_003C);
    writeReg(ADDR_PULSE_MASK, 32'hFFFF_FFFF);
    readReg(ADDR_PULSE_MASK);
    checkLiteral("addr 2 reads 0", readdata, 32'd0);
    writeReg(ADDR_OUTSET, 32'h0000_0001);
    for (int i = 0; i < 4; i++) readReg(ADDR_COUNT);
    checkLiteral("addr 3 reads 0", readdata, 32'd0);
    checkLiteral("no pulse logic", out_port, 32'h0000_003D);
    applyReset();
    readReg(3'd0);
    checkLiteral("DATA after reset", readdata, RV);
`endif

    readReg(3'd0);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
